// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin arbiter that fronts a single shared
//               combinational ALU. It accepts one command at a time, holds
//               the operands on the ALU for ALU_LAT cycles, then presents the
//               result to the owning requester until it is taken.
//               Optional grant statistics are enabled by the macro
//               ALU_ARB_STATS_EN. When it is undefined, o_gnt_cnt0 and
//               o_gnt_cnt1 are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int N       = 8,
  parameter int OPC_N   = 6,
  parameter int ALU_LAT = 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  // requester 0 command
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [OPC_N-1:0] i_req0_opc,
  input  logic [N-1:0]     i_req0_a,
  input  logic [N-1:0]     i_req0_b,
  // requester 1 command
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [OPC_N-1:0] i_req1_opc,
  input  logic [N-1:0]     i_req1_a,
  input  logic [N-1:0]     i_req1_b,
  // responses
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [N-1:0]     o_rsp0_data,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [N-1:0]     o_rsp1_data,
  // shared ALU
  output logic [OPC_N-1:0] o_alu_opc,
  output logic [N-1:0]     o_alu_a,
  output logic [N-1:0]     o_alu_b,
  input  logic [N-1:0]     i_alu_result,
  // status
  output logic             o_busy,
  output logic             o_owner,
  output logic [15:0]      o_gnt_cnt0,
  output logic [15:0]      o_gnt_cnt1
);

  // Counter reload value: EXEC lasts ALU_LAT cycles, counting down to zero.
  localparam logic [3:0] C_LAT_M1 = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last;      // requester served most recently
  logic             r_owner;     // requester currently granted
  logic [3:0]       r_cnt;       // EXEC cycles remaining minus one
  logic [OPC_N-1:0] r_opc;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_rsp0_data;
  logic [N-1:0]     r_rsp1_data;

  logic             w_sel;       // requester chosen while idle
  logic             w_hs0;
  logic             w_hs1;
  logic             w_hs;
  logic             w_exec_done;
  logic             w_take;

  // Pick a requester: a lone valid wins, a tie goes to the one not served last.
  always_comb begin
    w_sel = 1'b0;
    if (i_req1_valid && !i_req0_valid) begin
      w_sel = 1'b1;
    end else if (i_req0_valid && i_req1_valid) begin
      w_sel = ~r_last;
    end
  end

  assign w_hs0       = (r_state == ST_IDLE) && i_req0_valid && !w_sel;
  assign w_hs1       = (r_state == ST_IDLE) && i_req1_valid &&  w_sel;
  assign w_hs        = w_hs0 || w_hs1;
  assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == 4'd0);
  assign w_take      = (r_state == ST_RESP) &&
                       (r_owner ? i_rsp1_ready : i_rsp0_ready);

  // Ready is gated by reset so nothing is offered while reset is held low.
  assign o_req0_ready = i_reset && w_hs0;
  assign o_req1_ready = i_reset && w_hs1;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_hs)        w_state_nxt = ST_EXEC;
      ST_EXEC: if (w_exec_done) w_state_nxt = ST_RESP;
      ST_RESP: if (w_take)      w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, settle counter, result capture and round-robin pointer.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_cnt       <= 4'd0;
      r_opc       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp0_data <= '0;
      r_rsp1_data <= '0;
    end else begin
      if (w_hs) begin
        r_owner <= w_hs1;
        r_cnt   <= C_LAT_M1;
        r_opc   <= w_hs1 ? i_req1_opc : i_req0_opc;
        r_a     <= w_hs1 ? i_req1_a   : i_req0_a;
        r_b     <= w_hs1 ? i_req1_b   : i_req0_b;
      end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec_done) begin
        if (r_owner) begin
          r_rsp1_data <= i_alu_result;
        end else begin
          r_rsp0_data <= i_alu_result;
        end
      end
      if (w_take) begin
        r_last <= r_owner;
      end
    end
  end

  // The operand registers only change on a handshake, so the ALU inputs are
  // stable through EXEC and keep their last values everywhere else.
  assign o_alu_opc = r_opc;
  assign o_alu_a   = r_a;
  assign o_alu_b   = r_b;

  assign o_rsp0_valid = (r_state == ST_RESP) && !r_owner;
  assign o_rsp1_valid = (r_state == ST_RESP) &&  r_owner;
  assign o_rsp0_data  = r_rsp0_data;
  assign o_rsp1_data  = r_rsp1_data;

  assign o_busy  = (r_state != ST_IDLE);
  assign o_owner = r_owner;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  // Per-requester accepted-handshake counters, wrapping naturally at 16 bits.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_gnt_cnt0 <= 16'd0;
      r_gnt_cnt1 <= 16'd0;
    end else begin
      if (w_hs0) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      if (w_hs1) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
    end
  end

  assign o_gnt_cnt0 = r_gnt_cnt0;
  assign o_gnt_cnt1 = r_gnt_cnt1;
`else
  assign o_gnt_cnt0 = 16'd0;
  assign o_gnt_cnt1 = 16'd0;
`endif

endmodule
`default_nettype wire
